// File: rtl/lives_controller.sv
// lives_controller: player life-count sequencer.
// Tracks lives and runs the post-loss respawn freeze with HUD blinking.
// It also raises the game-over flag. Every output is registered.
module lives_controller #(
    parameter int INIT_LIVES     = 3,
    parameter int MAX_LIVES      = 9,
    parameter int RESPAWN_FRAMES = 120,
    parameter int BLINK_PERIOD   = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       newGame,
    input  logic       ballLost,
    input  logic       extraLife,
    output logic [3:0] lives,
    output logic       hudVisible,
    output logic       respawnActive,
    output logic       gameOver,
    output logic       livesChanged
);

    localparam int FRAME_W = $clog2(RESPAWN_FRAMES + 1);
    localparam int BLINK_W = $clog2(BLINK_PERIOD + 1);

    localparam logic [3:0]         INIT_L      = 4'(INIT_LIVES);
    localparam logic [3:0]         MAX_L       = 4'(MAX_LIVES);
    localparam logic [FRAME_W-1:0] FRAME_LAST  = FRAME_W'(RESPAWN_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_PERIOD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RESPAWN = 2'd2,
        OVER    = 2'd3
    } state_t;

    state_t             state_reg,     state_next;
    logic [3:0]         lives_reg,     lives_next;
    logic               hud_reg,       hud_next;
    logic               respawn_reg,   respawn_next;
    logic               over_reg,      over_next;
    logic               changed_reg,   changed_next;
    logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;

    // Incremented counter values used by the respawn timing logic.
    logic [FRAME_W-1:0] frame_inc;
    logic [BLINK_W-1:0] blink_inc;

    assign frame_inc = frame_cnt_reg + 1'b1;
    assign blink_inc = blink_cnt_reg + 1'b1;

    // State and output registers. The reset is asynchronous and returns all flags at once.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg     <= IDLE;
            lives_reg     <= INIT_L;
            hud_reg       <= 1'b1;
            respawn_reg   <= 1'b0;
            over_reg      <= 1'b0;
            changed_reg   <= 1'b0;
            frame_cnt_reg <= '0;
            blink_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            lives_reg     <= lives_next;
            hud_reg       <= hud_next;
            respawn_reg   <= respawn_next;
            over_reg      <= over_next;
            changed_reg   <= changed_next;
            frame_cnt_reg <= frame_cnt_next;
            blink_cnt_reg <= blink_cnt_next;
        end
    end

    // Next-state logic. newGame overrides every other event. In every other case, the current state decides what happens.
    always_comb begin
        state_next     = state_reg;
        lives_next     = lives_reg;
        hud_next       = hud_reg;
        respawn_next   = respawn_reg;
        over_next      = over_reg;
        changed_next   = 1'b0;
        frame_cnt_next = frame_cnt_reg;
        blink_cnt_next = blink_cnt_reg;

        if (newGame) begin
            state_next     = PLAY;
            lives_next     = INIT_L;
            hud_next       = 1'b1;
            respawn_next   = 1'b0;
            over_next      = 1'b0;
            changed_next   = (lives_reg != INIT_L);
            frame_cnt_next = '0;
            blink_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Nothing but newGame matters before a game starts.
                end

                PLAY: begin
                    if (ballLost && extraLife) begin
                        // The loss and the 1-up cancel out. Only the freeze remains.
                        state_next     = RESPAWN;
                        respawn_next   = 1'b1;
                        hud_next       = 1'b0;
                        frame_cnt_next = '0;
                        blink_cnt_next = '0;
                    end else if (ballLost) begin
                        if (lives_reg <= 4'd1) begin
                            state_next   = OVER;
                            lives_next   = 4'd0;
                            over_next    = 1'b1;
                            hud_next     = 1'b1;
                            respawn_next = 1'b0;
                            changed_next = (lives_reg != 4'd0);
                        end else begin
                            state_next     = RESPAWN;
                            lives_next     = lives_reg - 4'd1;
                            changed_next   = 1'b1;
                            respawn_next   = 1'b1;
                            hud_next       = 1'b0;
                            frame_cnt_next = '0;
                            blink_cnt_next = '0;
                        end
                    end else if (extraLife && (lives_reg < MAX_L)) begin
                        lives_next   = lives_reg + 4'd1;
                        changed_next = 1'b1;
                    end
                end

                RESPAWN: begin
                    if (extraLife && (lives_reg < MAX_L)) begin
                        lives_next   = lives_reg + 4'd1;
                        changed_next = 1'b1;
                    end
                    if (startOfFrame) begin
                        frame_cnt_next = frame_inc;
                        blink_cnt_next = blink_inc;
                        if (blink_inc == BLINK_LAST) begin
                            hud_next       = ~hud_reg;
                            blink_cnt_next = '0;
                        end
                        // At the end of the freeze the HUD is forced to visible, even if it was due to toggle.
                        if (frame_inc == FRAME_LAST) begin
                            state_next     = PLAY;
                            respawn_next   = 1'b0;
                            hud_next       = 1'b1;
                            frame_cnt_next = '0;
                            blink_cnt_next = '0;
                        end
                    end
                end

                OVER: begin
                    lives_next = 4'd0;
                    over_next  = 1'b1;
                    hud_next   = 1'b1;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign lives         = lives_reg;
    assign hudVisible    = hud_reg;
    assign respawnActive = respawn_reg;
    assign gameOver      = over_reg;
    assign livesChanged  = changed_reg;

endmodule

// File: tb/tb_lives_controller.sv
// Directed testbench for lives_controller with the default parameters.
module tb_lives_controller;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic       newGame;
    logic       ballLost;
    logic       extraLife;
    logic [3:0] lives;
    logic       hudVisible;
    logic       respawnActive;
    logic       gameOver;
    logic       livesChanged;

    int checks;
    int failures;

    lives_controller dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .newGame      (newGame),
        .ballLost     (ballLost),
        .extraLife    (extraLife),
        .lives        (lives),
        .hudVisible   (hudVisible),
        .respawnActive(respawnActive),
        .gameOver     (gameOver),
        .livesChanged (livesChanged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of pulses. Outputs are settled 1 time unit after the sampling edge.
    task automatic drive(input logic sof, input logic ng, input logic bl, input logic el);
        startOfFrame = sof;
        newGame      = ng;
        ballLost     = bl;
        extraLife    = el;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        newGame      = 1'b0;
        ballLost     = 1'b0;
        extraLife    = 1'b0;
    endtask

    // Send the remaining frame pulses of a respawn, starting from frame count 'done'.
    task automatic run_frames(input int done, input int total);
        for (int f = done + 1; f <= total; f++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        checks++; if (lives !== 4'd3)       begin failures++; $display("FAIL reset_lives got=%0d exp=3", lives); end
        checks++; if (hudVisible !== 1'b1)  begin failures++; $display("FAIL reset_hud got=%b exp=1", hudVisible); end
        checks++; if (respawnActive !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b exp=0", respawnActive); end
        checks++; if (gameOver !== 1'b0)    begin failures++; $display("FAIL reset_over got=%b exp=0", gameOver); end
        checks++; if (livesChanged !== 1'b0) begin failures++; $display("FAIL reset_changed got=%b exp=0", livesChanged); end
        $display("reset: lives=%0d hud=%b resp=%b over=%b", lives, hudVisible, respawnActive, gameOver);
    endtask

    task automatic test_idle_ignores;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        checks++; if (lives !== 4'd3)        begin failures++; $display("FAIL idle_lives got=%0d exp=3", lives); end
        checks++; if (respawnActive !== 1'b0) begin failures++; $display("FAIL idle_resp got=%b exp=0", respawnActive); end
        checks++; if (livesChanged !== 1'b0) begin failures++; $display("FAIL idle_changed got=%b exp=0", livesChanged); end
        $display("idle ballLost+extraLife: lives=%0d", lives);
    endtask

    task automatic test_new_game;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (lives !== 4'd3)        begin failures++; $display("FAIL ng_lives got=%0d exp=3", lives); end
        checks++; if (livesChanged !== 1'b0) begin failures++; $display("FAIL ng_changed got=%b exp=0", livesChanged); end
        checks++; if (gameOver !== 1'b0)     begin failures++; $display("FAIL ng_over got=%b exp=0", gameOver); end
        $display("newGame: lives=%0d changed=%b", lives, livesChanged);
    endtask

    task automatic test_respawn;
        logic exp_hud;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (lives !== 4'd2)         begin failures++; $display("FAIL loss_lives got=%0d exp=2", lives); end
        checks++; if (livesChanged !== 1'b1)  begin failures++; $display("FAIL loss_changed got=%b exp=1", livesChanged); end
        checks++; if (respawnActive !== 1'b1) begin failures++; $display("FAIL loss_resp got=%b exp=1", respawnActive); end
        checks++; if (hudVisible !== 1'b0)    begin failures++; $display("FAIL loss_hud got=%b exp=0", hudVisible); end
        $display("ballLost: lives=%0d changed=%b resp=%b hud=%b", lives, livesChanged, respawnActive, hudVisible);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (livesChanged !== 1'b0)  begin failures++; $display("FAIL loss_pulse_len got=%b exp=0", livesChanged); end
        for (int f = 1; f <= 120; f++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            exp_hud = (f == 120) ? 1'b1 : (((f / 8) % 2) == 1);
            checks++;
            if (hudVisible !== exp_hud) begin
                failures++; $display("FAIL blink_hud frame=%0d got=%b exp=%b", f, hudVisible, exp_hud);
            end
            checks++;
            if (respawnActive !== (f < 120)) begin
                failures++; $display("FAIL blink_resp frame=%0d got=%b exp=%b", f, respawnActive, (f < 120));
            end
        end
        $display("respawn done: resp=%b hud=%b lives=%0d", respawnActive, hudVisible, lives);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (respawnActive !== 1'b0 || hudVisible !== 1'b1) begin
            failures++; $display("FAIL sof_in_play got resp=%b hud=%b exp resp=0 hud=1", respawnActive, hudVisible);
        end
    endtask

    task automatic test_game_over;
        logic [3:0] exp_l;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (lives !== 4'd3 || livesChanged !== 1'b1) begin
            failures++; $display("FAIL ng_restore got lives=%0d chg=%b exp lives=3 chg=1", lives, livesChanged);
        end
        for (int k = 1; k <= 3; k++) begin
            exp_l = 4'(3 - k);
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            checks++; if (lives !== exp_l || livesChanged !== 1'b1) begin
                failures++; $display("FAIL loss%0d got lives=%0d chg=%b exp lives=%0d chg=1", k, lives, livesChanged, exp_l);
            end
            $display("loss %0d: lives=%0d over=%b", k, lives, gameOver);
            if (k < 3) begin
                drive(1'b0, 1'b0, 1'b1, 1'b0);
                checks++; if (lives !== exp_l) begin
                    failures++; $display("FAIL resp_ignore_loss got=%0d exp=%0d", lives, exp_l);
                end
                run_frames(0, 120);
                checks++; if (respawnActive !== 1'b0) begin
                    failures++; $display("FAIL resp_exit%0d got=%b exp=0", k, respawnActive);
                end
            end
        end
        checks++; if (gameOver !== 1'b1 || respawnActive !== 1'b0 || hudVisible !== 1'b1) begin
            failures++; $display("FAIL over_flags got over=%b resp=%b hud=%b exp 1/0/1", gameOver, respawnActive, hudVisible);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (lives !== 4'd0 || gameOver !== 1'b1 || livesChanged !== 1'b0) begin
            failures++; $display("FAIL over_ignore got lives=%0d over=%b chg=%b exp 0/1/0", lives, gameOver, livesChanged);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (lives !== 4'd3 || gameOver !== 1'b0 || livesChanged !== 1'b1) begin
            failures++; $display("FAIL over_newgame got lives=%0d over=%b chg=%b exp 3/0/1", lives, gameOver, livesChanged);
        end
        $display("newGame from OVER: lives=%0d over=%b", lives, gameOver);
    endtask

    task automatic test_extra_life;
        logic [3:0] exp_l;
        for (int i = 1; i <= 7; i++) begin
            exp_l = (3 + i > 9) ? 4'd9 : 4'(3 + i);
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            checks++; if (lives !== exp_l || livesChanged !== (i <= 6)) begin
                failures++; $display("FAIL extra%0d got lives=%0d chg=%b exp lives=%0d chg=%b", i, lives, livesChanged, exp_l, (i <= 6));
            end
            $display("extraLife %0d: lives=%0d changed=%b", i, lives, livesChanged);
        end
    endtask

    task automatic test_simultaneous;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (lives !== 4'd9 || livesChanged !== 1'b0 || respawnActive !== 1'b1) begin
            failures++; $display("FAIL both_at9 got lives=%0d chg=%b resp=%b exp 9/0/1", lives, livesChanged, respawnActive);
        end
        $display("both at 9: lives=%0d resp=%b", lives, respawnActive);
        run_frames(0, 120);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        run_frames(0, 120);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        run_frames(0, 120);
        checks++; if (lives !== 4'd1 || respawnActive !== 1'b0) begin
            failures++; $display("FAIL setup_one got lives=%0d resp=%b exp 1/0", lives, respawnActive);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (lives !== 4'd1 || gameOver !== 1'b0 || respawnActive !== 1'b1 || livesChanged !== 1'b0) begin
            failures++; $display("FAIL both_at1 got lives=%0d over=%b resp=%b chg=%b exp 1/0/1/0", lives, gameOver, respawnActive, livesChanged);
        end
        $display("both at 1: lives=%0d over=%b resp=%b", lives, gameOver, respawnActive);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (lives !== 4'd2 || livesChanged !== 1'b1 || respawnActive !== 1'b1) begin
            failures++; $display("FAIL extra_in_resp got lives=%0d chg=%b resp=%b exp 2/1/1", lives, livesChanged, respawnActive);
        end
        run_frames(0, 120);
    endtask

    task automatic test_async_reset;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        run_frames(0, 60);
        #2 resetN = 1'b0;
        #1;
        checks++; if (lives !== 4'd3 || respawnActive !== 1'b0 || hudVisible !== 1'b1 || gameOver !== 1'b0) begin
            failures++; $display("FAIL async_reset got lives=%0d resp=%b hud=%b over=%b exp 3/0/1/0", lives, respawnActive, hudVisible, gameOver);
        end
        $display("async reset mid-respawn: lives=%0d resp=%b hud=%b", lives, respawnActive, hudVisible);
        @(negedge clk);
        resetN = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (lives !== 4'd3 || respawnActive !== 1'b0 || livesChanged !== 1'b0) begin
            failures++; $display("FAIL ng_with_loss got lives=%0d resp=%b chg=%b exp 3/0/0", lives, respawnActive, livesChanged);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (lives !== 4'd2 || respawnActive !== 1'b1) begin
            failures++; $display("FAIL play_after_ng got lives=%0d resp=%b exp 2/1", lives, respawnActive);
        end
        $display("newGame+ballLost then ballLost: lives=%0d resp=%b", lives, respawnActive);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        newGame      = 1'b0;
        ballLost     = 1'b0;
        extraLife    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        resetN = 1'b1;
        test_idle_ignores;
        test_new_game;
        test_respawn;
        test_game_over;
        test_extra_life;
        test_simultaneous;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
